// File: rtl/level_countdown_timer_if.sv
// Control/status bundle between the game state FSM and the level countdown timer.
//   load         one-cycle pulse: capture start digits and run
//   start_left   BCD tens digit of the start time
//   start_right  BCD ones digit of the start time
//   pause        level: hold the count while high
//   freeze       level: stop and hold the display (win/fail reached)
//   time_left    BCD tens digit remaining
//   time_right   BCD ones digit remaining
//   expired      one-cycle pulse when the count reaches 00
//   running      high while counting
//   warn         low-time indicator
// The master modport is the controlling side (state FSM); the slave modport is the timer.
interface level_countdown_timer_if;
    logic       load;
    logic [3:0] start_left;
    logic [3:0] start_right;
    logic       pause;
    logic       freeze;
    logic [3:0] time_left;
    logic [3:0] time_right;
    logic       expired;
    logic       running;
    logic       warn;

    modport master (
        output load, start_left, start_right, pause, freeze,
        input  time_left, time_right, expired, running, warn
    );

    modport slave (
        input  load, start_left, start_right, pause, freeze,
        output time_left, time_right, expired, running, warn
    );
endinterface

// File: rtl/level_countdown_timer.sv
// Per-level countdown timer for the password game.
// Loads a two-digit BCD start time on load, decrements once per TICKS_PER_SEC clocks,
// supports pause (prescaler held) and freeze (stop, hold display), and pulses expired
// for one cycle when the count reaches 00. All outputs are registered.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset
//   ctrl   slave side of level_countdown_timer_if (controls in, time/status out)
module level_countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned WARN_SECS     = 10
) (
    input logic                    clk,
    input logic                    reset,
    level_countdown_timer_if.slave ctrl
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LastTick = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    WarnSecs = 7'(WARN_SECS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StExpired
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    left_q, left_d;
    logic [3:0]    right_q, right_d;
    logic          expired_q, expired_d;
    logic          running_q, running_d;
    logic          warn_q, warn_d;

    logic [3:0]    load_left;
    logic [3:0]    load_right;
    logic [6:0]    secs_d;

    // Out-of-range BCD inputs saturate at 9.
    assign load_left  = (ctrl.start_left  > 4'd9) ? 4'd9 : ctrl.start_left;
    assign load_right = (ctrl.start_right > 4'd9) ? 4'd9 : ctrl.start_right;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        left_d    = left_q;
        right_d   = right_q;
        expired_d = 1'b0;

        if (ctrl.freeze) begin
            state_d = StIdle;
            presc_d = '0;
        end else if (ctrl.load) begin
            // Load beats a coincident wrap: no decrement, no expired pulse from the old count.
            left_d  = load_left;
            right_d = load_right;
            presc_d = '0;
            if (load_left == 4'd0 && load_right == 4'd0) begin
                state_d   = StExpired;
                expired_d = 1'b1;
            end else begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    presc_d = '0;
                end
                StRun: begin
                    if (ctrl.pause) begin
                        state_d = StPause;
                    end else if (presc_q == LastTick) begin
                        presc_d = '0;
                        if (right_q != 4'd0) begin
                            right_d = right_q - 4'd1;
                        end else if (left_q != 4'd0) begin
                            right_d = 4'd9;
                            left_d  = left_q - 4'd1;
                        end
                        if (left_d == 4'd0 && right_d == 4'd0) begin
                            state_d   = StExpired;
                            expired_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                StPause: begin
                    // Prescaler is held so the partial second resumes where it stopped.
                    if (!ctrl.pause) begin
                        state_d = StRun;
                    end
                end
                StExpired: begin
                    presc_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    presc_d = '0;
                end
            endcase
        end
    end

    // Remaining seconds for the warn compare; max 99 fits in 7 bits.
    assign secs_d = ({3'b000, left_d} << 3) + ({3'b000, left_d} << 1) + {3'b000, right_d};

    always_comb begin
        running_d = (state_d == StRun);
        warn_d    = ((state_d == StRun) || (state_d == StPause)) && (secs_d < WarnSecs);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            left_q    <= 4'd0;
            right_q   <= 4'd0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            left_q    <= left_d;
            right_q   <= right_d;
            expired_q <= expired_d;
            running_q <= running_d;
            warn_q    <= warn_d;
        end
    end

    assign ctrl.time_left  = left_q;
    assign ctrl.time_right = right_q;
    assign ctrl.expired    = expired_q;
    assign ctrl.running    = running_q;
    assign ctrl.warn       = warn_q;

endmodule

// File: tb/tb_level_countdown_timer.sv
// Directed bench for level_countdown_timer with TICKS_PER_SEC=4, WARN_SECS=10.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_level_countdown_timer;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    int   exp_seen;

    level_countdown_timer_if tif ();

    level_countdown_timer #(
        .TICKS_PER_SEC(4),
        .WARN_SECS    (10)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .ctrl (tif)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_digits(input string tag, input int l, input int r);
        check_eq({tag, ".left"}, int'(tif.time_left), l);
        check_eq({tag, ".right"}, int'(tif.time_right), r);
    endtask

    // Pulse load for one edge with the given start digits.
    task automatic do_load(input logic [3:0] l, input logic [3:0] r);
        tif.load        = 1'b1;
        tif.start_left  = l;
        tif.start_right = r;
        tick();
        tif.load = 1'b0;
    endtask

    // Advance n edges, counting edges on which expired was high.
    task automatic watch_expired(input int n);
        repeat (n) begin
            tick();
            if (tif.expired) exp_seen++;
        end
    endtask

    initial begin
        reset           = 1'b1;
        tif.load        = 1'b0;
        tif.start_left  = 4'd0;
        tif.start_right = 4'd0;
        tif.pause       = 1'b0;
        tif.freeze      = 1'b0;
        tick(2);
        reset = 1'b0;
        check_digits("reset", 0, 0);
        check_eq("reset.expired", int'(tif.expired), 0);
        check_eq("reset.running", int'(tif.running), 0);
        check_eq("reset.warn", int'(tif.warn), 0);

        // 90 seconds down to expiry.
        do_load(4'd9, 4'd0);
        check_digits("load90", 9, 0);
        check_eq("load90.running", int'(tif.running), 1);
        check_eq("load90.warn", int'(tif.warn), 0);
        tick(3);
        check_digits("load90.pre", 9, 0);
        tick();
        check_digits("load90.first", 8, 9);
        tick(355);
        check_digits("load90.at01", 0, 1);
        check_eq("load90.at01.expired", int'(tif.expired), 0);
        check_eq("load90.at01.warn", int'(tif.warn), 1);
        tick();
        check_digits("load90.end", 0, 0);
        check_eq("load90.end.expired", int'(tif.expired), 1);
        check_eq("load90.end.running", int'(tif.running), 0);
        check_eq("load90.end.warn", int'(tif.warn), 0);
        tick();
        check_eq("load90.end.expired_drop", int'(tif.expired), 0);
        check_digits("load90.hold", 0, 0);
        tick(10);
        check_digits("load90.hold2", 0, 0);
        check_eq("load90.hold2.expired", int'(tif.expired), 0);

        // Pause holds the prescaler at 2; resume wraps two edges later.
        do_load(4'd3, 4'd0);
        tick(2);
        tif.pause = 1'b1;
        tick(10);
        check_eq("pause.running", int'(tif.running), 0);
        check_digits("pause.hold", 3, 0);
        tif.pause = 1'b0;
        tick();
        check_eq("pause.resume.running", int'(tif.running), 1);
        tick();
        check_digits("pause.resume1", 3, 0);
        tick();
        check_digits("pause.resume2", 2, 9);

        // Load on the wrap edge that would have taken 01 to 00.
        do_load(4'd0, 4'd2);
        tick(4);
        check_digits("wrapload.at01", 0, 1);
        check_eq("wrapload.at01.warn", int'(tif.warn), 1);
        tick(3);
        exp_seen = 0;
        tif.load        = 1'b1;
        tif.start_left  = 4'd6;
        tif.start_right = 4'd0;
        tick();
        tif.load = 1'b0;
        if (tif.expired) exp_seen++;
        check_digits("wrapload.after", 6, 0);
        check_eq("wrapload.running", int'(tif.running), 1);
        watch_expired(6);
        check_eq("wrapload.no_expired", exp_seen, 0);
        check_digits("wrapload.later", 5, 9);

        // Freeze at 30 holds the display in idle.
        do_load(4'd3, 4'd1);
        tick(4);
        check_digits("freeze.pre", 3, 0);
        exp_seen = 0;
        tif.freeze = 1'b1;
        tick();
        tif.freeze = 1'b0;
        if (tif.expired) exp_seen++;
        check_eq("freeze.running", int'(tif.running), 0);
        tif.pause = 1'b1;
        watch_expired(10);
        tif.pause = 1'b0;
        watch_expired(10);
        check_digits("freeze.hold", 3, 0);
        check_eq("freeze.idle.running", int'(tif.running), 0);
        check_eq("freeze.warn", int'(tif.warn), 0);
        check_eq("freeze.no_expired", exp_seen, 0);
        do_load(4'd6, 4'd0);
        check_digits("freeze.reload", 6, 0);
        check_eq("freeze.reload.running", int'(tif.running), 1);
        tick(4);
        check_digits("freeze.reload.dec", 5, 9);

        // Warn crosses at 10 -> 09.
        do_load(4'd1, 4'd0);
        check_eq("warn.at10", int'(tif.warn), 0);
        tick(4);
        check_digits("warn.dec", 0, 9);
        check_eq("warn.at09", int'(tif.warn), 1);
        tif.pause = 1'b1;
        tick();
        check_eq("warn.paused", int'(tif.warn), 1);
        tif.pause = 1'b0;

        // Loading 00 expires immediately with a single pulse.
        do_load(4'd0, 4'd0);
        check_eq("load00.expired", int'(tif.expired), 1);
        check_eq("load00.running", int'(tif.running), 0);
        check_eq("load00.warn", int'(tif.warn), 0);
        exp_seen = 0;
        watch_expired(8);
        check_eq("load00.single_pulse", exp_seen, 0);

        // Out-of-range BCD clamps to 9.
        do_load(4'd12, 4'd15);
        check_digits("clamp", 9, 9);
        check_eq("clamp.running", int'(tif.running), 1);
        tick(4);
        check_digits("clamp.dec", 9, 8);

        // Reset mid-run returns to the reset state.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_digits("rerun.reset", 0, 0);
        check_eq("rerun.reset.running", int'(tif.running), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
